digit_scan_demux: RTL and testbench
===================================

Name: digit_scan_demux

Overview:
- Display-side scanner for the stopwatch.
- Takes 8 BCD digits and time-multiplexes them onto one shared active-low 7-segment bus.
- Drives a one-hot active-low anode enable: a 3-to-8 demux, counter-driven at a programmable scan rate.
- Sits between the stopwatch counter/formatting logic and the board display pins.

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot (1 guard cycle + SCAN_DIV-1 drive cycles); legal range ≥ 2.
- N_DIGITS, 8, number of digits scanned (1..8); anodes at index ≥ N_DIGITS are never asserted.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; low blanks the display and freezes the scan.
- digits_in  input  32  8 BCD nibbles; digit k = digits_in[4k+3:4k], digit 0 is rightmost.
- dp_in  input  8  decimal point request per digit, active-high.
- an_out  output  8  anode enables, active-low, at most one bit low.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_out  output  1  decimal point, active-low.
- digit_sel  output  3  index of the current slot.
- frame_tick  output  1  one-cycle pulse at the start of each full scan frame.

Behaviour:
- Reset (async, rst=1): an_out=8'hFF, seg_out=7'h7F, dp_out=1, digit_sel=0, frame_tick=0, prescaler=0, state=IDLE. Reset mid-slot aborts immediately, with no partial drive.
- All outputs are registered. No combinational path exists from inputs to outputs.
- FSM states:
  - IDLE: en=0. Outputs blanked (an_out=FF, seg_out=7F, dp_out=1). digit_sel holds. Prescaler is cleared.
  - GUARD: exactly 1 cycle.
    - an_out=FF.
    - digit_sel updated to the new index.
    - Snapshot of digits_in/dp_in for that index taken.
    - seg_out/dp_out loaded from the snapshot.
  - DRIVE: SCAN_DIV-1 cycles.
    - an_out[digit_sel]=0.
    - seg_out/dp_out hold the snapshot. Input changes are ignored until the next GUARD.
- Transitions:
  - IDLE→GUARD when en=1. The first slot after IDLE uses the held digit_sel; from reset this is digit 0.
  - GUARD→DRIVE unconditionally.
  - DRIVE→GUARD when prescaler==SCAN_DIV-1. On this transition the index advances: (digit_sel==N_DIGITS-1) ? 0 : digit_sel+1.
  - Any state→IDLE on the cycle after en samples 0. Outputs blank in that same registered update.
- Prescaler:
  - Width $clog2(SCAN_DIV).
  - Counts 0..SCAN_DIV-1 across GUARD+DRIVE, then wraps to 0. No overflow beyond SCAN_DIV-1.
- frame_tick: asserted for 1 cycle in the GUARD of index 0 when entered by wrap from N_DIGITS-1. It is not asserted on the IDLE→GUARD entry.
- BCD decode:
  - 0-9 map to the standard patterns, e.g. 0→7'h40, 1→7'h79, 8→7'h00.
  - Nibble values 10-15 decode to blank (7'h7F). dp still honoured.
- N_DIGITS=1: every slot is index 0. frame_tick fires on every GUARD except the first after IDLE.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - During GUARD, digit k (k ≥ 1) is blanked (seg_out=7'h7F) when its nibble and all higher digits below N_DIGITS are 0.
  - Digit 0 is never blanked.
  - dp_in overrides blanking for that digit's dp_out only.
  - Evaluated on the same GUARD snapshot.
- Undefined: all digits are decoded literally; zeros are shown.

Decomposition:
- Package digit_scan_pkg:
  - State enum scan_state_t {IDLE, GUARD, DRIVE}.
  - SEG_BLANK=7'h7F.
  - SEG_LUT constant array for 0-9.
  - Function seg_decode(nibble) returning 7 bits.
- One sub-module: bcd_to_seg7 (combinational wrapper around seg_decode). It is instantiated once; its result is registered in the top.

Test Plan (SCAN_DIV=4, N_DIGITS=8 unless noted):
1. Reset then en=1, digits_in=32'h76543210:
   - an_out sequence per slot is FF, then FE for 3 cycles.
   - seg_out=40 in digit 0's slot, 79 in digit 1's.
   - Digit 7 is reached at cycle 28; frame_tick pulses once at cycle 32.
2. Change digits_in mid-DRIVE of digit 2: seg_out is unchanged until the next GUARD; the new value appears in the following frame's digit 2 slot.
3. Drop en during DRIVE of digit 5:
   - Next cycle an_out=FF, seg_out=7F.
   - Re-enable: GUARD for digit 5, with no frame_tick.
4. Assert rst asynchronously mid-DRIVE: an_out=FF, digit_sel=0 without waiting for a clk edge.
5. Nibble 4'hC with dp_in[3]=1: digit 3 slot shows seg_out=7F, dp_out=0. With N_DIGITS=4, an_out bits 7:4 are never low.
6. LEADING_ZERO_BLANK_EN defined, digits_in=32'h00000105:
   - Digits 7..3 show 7F.
   - Digit 2 shows 79, digit 1 shows 40, digit 0 shows the pattern for 5.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Purpose: shared types and 7-segment decode table for the digit scanner.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: scan_state_t FSM encoding, SEG_BLANK / AN_BLANK constants,
//           SEG_LUT patterns for 0-9, seg_decode() nibble -> {g,f,e,d,c,b,a}.
package digit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_BLANK  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Non-BCD nibbles (10-15) show nothing rather than a garbage glyph.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] pattern;
    pattern = SEG_BLANK;
    if (nibble < 4'd10) begin
      pattern = SEG_LUT[nibble];
    end
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Purpose: combinational BCD nibble to active-low 7-segment pattern.
// Latency: 0 cycles (pure combinational; the caller registers the result).
// Backpressure: none.
// Ports: nibble_i [3:0] BCD digit in; seg_o [6:0] {g,f,e,d,c,b,a}, active-low.
module bcd_to_seg7
  import digit_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(nibble_i);

endmodule

// File: rtl/digit_scan_demux.sv
// Purpose: time-multiplexes up to 8 BCD digits onto one active-low 7-seg bus.
// Latency: outputs registered; a digit snapshot appears 1 cycle after its GUARD edge.
// Backpressure: none; en=0 blanks the display and freezes the scan index.
// Ports: clk, rst (async active-high), en, digits_in[31:0] (nibble k = digit k),
//        dp_in[7:0]; outputs an_out[7:0] and seg_out[6:0]/dp_out (all active-low),
//        digit_sel[2:0] current slot, frame_tick one-cycle frame-start pulse.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module digit_scan_demux
  import digit_scan_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int N_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [2:0]  digit_sel,
  output logic        frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]    SEL_LAST   = 3'(N_DIGITS - 1);

  scan_state_t   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          ft_q, ft_d;

  // High when the next registered update is a GUARD (snapshot point).
  logic          load;
  logic [3:0]    snap_nibble;
  logic [6:0]    snap_seg;
  logic          lz_blank;

  // The decoder looks at the slot being entered, not the one being left.
  assign snap_nibble = digits_in[{sel_d, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .nibble_i (snap_nibble),
    .seg_o    (snap_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // zero_run[k]: digit k and every higher populated digit are all zero.
  logic [7:0] zero_run;
  logic       run;
  always_comb begin
    zero_run = 8'hFF;
    run      = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      if (k < N_DIGITS) begin
        run = run & (digits_in[4*k +: 4] == 4'd0);
      end
      zero_run[k] = run;
    end
  end
  assign lz_blank = (sel_d != 3'd0) && zero_run[sel_d];
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sel_d   = sel_q;
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    ft_d    = 1'b0;
    load    = 1'b0;

    if (!en) begin
      state_d = IDLE;
      presc_d = '0;
      an_d    = AN_BLANK;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Resume on the held index; no frame_tick on this entry.
          state_d = GUARD;
          presc_d = '0;
          load    = 1'b1;
        end
        GUARD: begin
          state_d = DRIVE;
          presc_d = presc_q + 1'b1;
          an_d    = ~(8'h01 << sel_q);
        end
        DRIVE: begin
          if (presc_q == PRESC_LAST) begin
            state_d = GUARD;
            presc_d = '0;
            sel_d   = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
            ft_d    = (sel_q == SEL_LAST);
            load    = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
          an_d    = AN_BLANK;
          seg_d   = SEG_BLANK;
          dp_d    = 1'b1;
        end
      endcase
    end

    // GUARD entry: anodes off while segments settle on the new snapshot.
    if (load) begin
      an_d  = AN_BLANK;
      seg_d = lz_blank ? SEG_BLANK : snap_seg;
      dp_d  = ~dp_in[sel_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      sel_q   <= 3'd0;
      an_q    <= AN_BLANK;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      ft_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      ft_q    <= ft_d;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign digit_sel  = sel_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_digit_scan_demux.sv
module tb_digit_scan_demux;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;

  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [2:0]  sel0, sel1;
  logic        ft0, ft1;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  digit_scan_demux #(.SCAN_DIV(SD), .N_DIGITS(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .an_out(an0), .seg_out(seg0), .dp_out(dp0), .digit_sel(sel0), .frame_tick(ft0)
  );

  digit_scan_demux #(.SCAN_DIV(SD), .N_DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .an_out(an1), .seg_out(seg1), .dp_out(dp1), .digit_sel(sel1), .frame_tick(ft1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in a run is plain arithmetic on cycles since enable:
  // slot = (start + t / SD) % N, phase = t % SD (phase 0 is the guard cycle).
  bit         m_act [2];
  int         m_t   [2];
  int         m_start [2];
  int         m_idx [2];
  logic [7:0] e_an  [2];
  logic [6:0] e_seg [2];
  logic       e_dp  [2];
  logic       e_ft  [2];

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic bit lead_zero(input int idx, input int n, input logic [31:0] d);
    if (idx == 0) return 1'b0;
    for (int j = idx; j < n; j++) begin
      if (d[4*j +: 4] != 4'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic mstep(input int i);
    int n;
    int ph;
    bit blank;
    n = (i == 0) ? 8 : 4;
    e_ft[i] = 1'b0;
    if (rst) begin
      m_act[i] = 1'b0; m_idx[i] = 0;
      e_an[i] = 8'hFF; e_seg[i] = 7'h7F; e_dp[i] = 1'b1;
    end else if (!en) begin
      m_act[i] = 1'b0;
      e_an[i] = 8'hFF; e_seg[i] = 7'h7F; e_dp[i] = 1'b1;
    end else begin
      if (!m_act[i]) begin
        m_act[i] = 1'b1; m_t[i] = 0; m_start[i] = m_idx[i];
      end else begin
        m_t[i]++;
      end
      m_idx[i] = (m_start[i] + m_t[i] / SD) % n;
      ph = m_t[i] % SD;
      if (ph == 0) begin
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = lead_zero(m_idx[i], n, digits_in);
`endif
        e_an[i]  = 8'hFF;
        e_seg[i] = blank ? 7'h7F : pat(digits_in[4*m_idx[i] +: 4]);
        e_dp[i]  = ~dp_in[m_idx[i]];
        e_ft[i]  = (m_t[i] > 0) && (m_idx[i] == 0);
      end else begin
        e_an[i] = ~(8'h01 << m_idx[i]);
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) mstep(i);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("an8",  {24'd0, an0},  {24'd0, e_an[0]});
      check("seg8", {25'd0, seg0}, {25'd0, e_seg[0]});
      check("dp8",  {31'd0, dp0},  {31'd0, e_dp[0]});
      check("sel8", {29'd0, sel0}, 32'(m_idx[0]));
      check("ft8",  {31'd0, ft0},  {31'd0, e_ft[0]});
      check("an4",  {24'd0, an1},  {24'd0, e_an[1]});
      check("seg4", {25'd0, seg1}, {25'd0, e_seg[1]});
      check("dp4",  {31'd0, dp1},  {31'd0, e_dp[1]});
      check("sel4", {29'd0, sel1}, 32'(m_idx[1]));
      check("ft4",  {31'd0, ft1},  {31'd0, e_ft[1]});
    end
  end

  // Wait (bounded) until the 8-digit instance shows the GUARD of slot k.
  task automatic wait_guard(input int k);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (en && an0 == 8'hFF && sel0 == 3'(k)) found = 1'b1;
    end
    if (!found) check("guard_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; digits_in = '0; dp_in = '0;
    repeat (2) @(negedge clk);
    check("rst_an",  {24'd0, an0},  32'hFF);
    check("rst_seg", {25'd0, seg0}, 32'h7F);
    check("rst_dp",  {31'd0, dp0},  32'd1);
    check("rst_sel", {29'd0, sel0}, 32'd0);
    check("rst_ft",  {31'd0, ft0},  32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Scan 76543210 from reset; slot k guard is observed at tick 4k+1.
    @(negedge clk);
    digits_in = 32'h76543210; en = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c == 1)  begin check("t1_an_g", {24'd0, an0}, 32'hFF); check("t1_seg0", {25'd0, seg0}, 32'h40); end
      if (c == 2)  check("t1_an_d", {24'd0, an0}, 32'hFE);
      if (c == 4)  check("t1_an_d3", {24'd0, an0}, 32'hFE);
      if (c == 5)  check("t1_seg1", {25'd0, seg0}, 32'h79);
      if (c == 29) check("t1_sel7", {29'd0, sel0}, 32'd7);
      if (c == 32) check("t1_noft", {31'd0, ft0}, 32'd0);
      if (c == 33) check("t1_ft",   {31'd0, ft0}, 32'd1);
    end

    // Mid-drive change of digit 2 is ignored until its next guard.
    wait_guard(2);
    @(negedge clk);
    digits_in = 32'h76543910;
    @(negedge clk);
    check("t2_hold", {25'd0, seg0}, 32'h24);
    wait_guard(3);
    wait_guard(2);
    check("t2_new", {25'd0, seg0}, 32'h10);

    // Drop enable during digit 5 drive, then resume on digit 5.
    wait_guard(5);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("t3_an",  {24'd0, an0},  32'hFF);
    check("t3_seg", {25'd0, seg0}, 32'h7F);
    en = 1'b1;
    @(negedge clk);
    check("t3_sel", {29'd0, sel0}, 32'd5);
    check("t3_ft",  {31'd0, ft0},  32'd0);
    @(negedge clk);
    check("t3_an5", {24'd0, an0}, 32'hDF);

    // Asynchronous reset mid-drive, checked before any clock edge.
    wait_guard(6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_an",  {24'd0, an0},  32'hFF);
    check("t4_sel", {29'd0, sel0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Non-BCD nibble blanks segments but keeps the decimal point.
    digits_in = 32'h1234C567; dp_in = 8'h08;
    wait_guard(3);
    check("t5_seg8", {25'd0, seg0}, 32'h7F);
    check("t5_dp8",  {31'd0, dp0},  32'd0);
    check("t5_seg4", {25'd0, seg1}, 32'h7F);
    check("t5_dp4",  {31'd0, dp1},  32'd0);

    // Leading zeros: blanked with the option, shown literally without it.
    digits_in = 32'h00000105; dp_in = 8'h00;
    wait_guard(7);
`ifdef LEADING_ZERO_BLANK_EN
    check("t6_d7", {25'd0, seg0}, 32'h7F);
    wait_guard(3);
    check("t6_d3", {25'd0, seg0}, 32'h7F);
`else
    check("t6_d7", {25'd0, seg0}, 32'h40);
    wait_guard(3);
    check("t6_d3", {25'd0, seg0}, 32'h40);
`endif
    wait_guard(2);
    check("t6_d2", {25'd0, seg0}, 32'h79);
    wait_guard(1);
    check("t6_d1", {25'd0, seg0}, 32'h40);
    wait_guard(0);
    check("t6_d0", {25'd0, seg0}, 32'h12);

    // Randomized traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF >> (4 * $urandom_range(0, 8));
        digits_in = $urandom & mask;
      end
      if ($urandom_range(0, 5) == 0) dp_in = 8'($urandom);
      if (en) begin
        if ($urandom_range(0, 79) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) en = 1'b1;
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
